// File: rtl/sequential_div_if.sv
// sequential_div_if
// Handshake and operand/result bundle for the sequential divider.
//   start       : request a division (sampled by the divider only while idle)
//   dividend    : unsigned dividend, WIDTH bits
//   divisor     : unsigned divisor, WIDTH bits
//   quotient    : registered quotient, WIDTH bits
//   remainder   : registered remainder, WIDTH bits
//   done        : one-cycle completion pulse, results valid in the same cycle
//   busy        : a division is in progress
//   div_by_zero : last completed division had a zero divisor
// The master modport issues requests; the slave modport is the divider side.
interface sequential_div_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/sequential_div.sv
// sequential_div
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, aborts any division in progress
//   bus  : sequential_div_if.slave carrying start/dividend/divisor in and
//          quotient/remainder/done/busy/div_by_zero out
// A normal division takes WIDTH+1 edges from acceptance to done; a zero
// divisor skips the shift loop and completes one edge after acceptance with
// quotient all ones and remainder equal to the dividend.
module sequential_div #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  sequential_div_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers: dvd_q shifts the dividend out at the top while the
  // quotient bits shift in at the bottom, so it ends up holding the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q;

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remo_q;
  logic             done_q;
  logic             dbz_q;

  logic             load_ops;
  logic             do_step;
  logic             do_finish;
  logic             busy_c;
  logic             last_step;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.divisor == '0) ? FINISH : DIVIDE;
        end
      end
      DIVIDE: begin
        if (last_step) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    load_ops  = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        load_ops = bus.start;
      end
      DIVIDE: begin
        do_step = 1'b1;
        busy_c  = 1'b1;
      end
      FINISH: begin
        do_finish = 1'b1;
        busy_c    = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  // One restoring step. The compare is WIDTH+1 bits wide; when it succeeds
  // the difference is below the divisor, so its low WIDTH bits are exact and
  // the subtraction can be done at WIDTH bits.
  always_comb begin
    trial    = {rem_q, dvd_q[WIDTH-1]};
    fits     = (trial >= {1'b0, dvs_q});
    rem_step = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
    dvd_step = {dvd_q[WIDTH-2:0], fits};
  end

  // Datapath and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      quot_q <= '0;
      remo_q <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_ops) begin
        dvd_q  <= bus.dividend;
        dvs_q  <= bus.divisor;
        rem_q  <= '0;
        cnt_q  <= '0;
        zero_q <= (bus.divisor == '0);
      end
      if (do_step) begin
        dvd_q <= dvd_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q + 1'b1;
      end
      if (do_finish) begin
        done_q <= 1'b1;
        if (zero_q) begin
          quot_q <= '1;
          remo_q <= dvd_q;
          dbz_q  <= 1'b1;
        end else begin
          quot_q <= dvd_q;
          remo_q <= rem_q;
          dbz_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy_c;

endmodule

// File: tb/tb_sequential_div.sv
// tb_sequential_div
// Self-checking bench for sequential_div. A WIDTH=4 instance gets directed
// scenarios, an exhaustive sweep and random pairs; a WIDTH=8 instance gets
// random pairs. Expected results come from plain / and % arithmetic.
module tb_sequential_div;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  sequential_div_if #(.WIDTH(4)) bus  ();
  sequential_div_if #(.WIDTH(8)) bus8 ();

  sequential_div #(.WIDTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sequential_div #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic doDiv(input string tag, input logic [3:0] a, input logic [3:0] b);
    int         n;
    int         busy_cnt;
    logic [3:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_z;
    exp_z = (b == 4'd0);
    exp_q = exp_z ? 4'hF : a / b;
    exp_r = exp_z ? a : a % b;
    applyStimulus(a, b);
    n = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, n, exp_z ? 1 : 5);
    checkOutput({tag, "_busycycles"}, busy_cnt, exp_z ? 1 : 5);
    checkOutput($sformatf("%s_q(%0d/%0d)", tag, a, b), bus.quotient, exp_q);
    checkOutput($sformatf("%s_r(%0d/%0d)", tag, a, b), bus.remainder, exp_r);
    checkOutput({tag, "_dbz"}, bus.div_by_zero, exp_z);
    checkOutput({tag, "_busy_at_done"}, bus.busy, 0);
    tick();
    checkOutput({tag, "_done_clear"}, bus.done, 0);
    checkOutput({tag, "_q_hold"}, bus.quotient, exp_q);
  endtask

  task automatic doDiv8(input logic [7:0] a, input logic [7:0] b);
    int         n;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_z;
    exp_z = (b == 8'd0);
    exp_q = exp_z ? 8'hFF : a / b;
    exp_r = exp_z ? a : a % b;
    bus8.start    = 1'b1;
    bus8.dividend = a;
    bus8.divisor  = b;
    tick();
    bus8.start = 1'b0;
    n = 0;
    while (bus8.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("w8_latency", n, exp_z ? 1 : 9);
    checkOutput($sformatf("w8_q(%0d/%0d)", a, b), bus8.quotient, exp_q);
    checkOutput($sformatf("w8_r(%0d/%0d)", a, b), bus8.remainder, exp_r);
    checkOutput("w8_dbz", bus8.div_by_zero, exp_z);
    tick();
  endtask

  initial begin
    int done_cnt;
    logic [7:0] ra;
    logic [7:0] rb;
    vectors     = 0;
    miscompares = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus8.start    = 1'b0;
    bus8.dividend = '0;
    bus8.divisor  = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_q", bus.quotient, 0);
    checkOutput("rst_r", bus.remainder, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    tick();

    // Basic quotient and remainder
    doDiv("basic", 4'd13, 4'd3);
    doDiv("basic", 4'd15, 4'd1);
    doDiv("basic", 4'd2,  4'd9);
    doDiv("basic", 4'd15, 4'd15);

    // Divide by zero, then recovery
    doDiv("dbz", 4'd7, 4'd0);
    doDiv("after_dbz", 4'd8, 4'd2);

    // Busy protection: a second request during busy is neither honoured nor queued
    applyStimulus(4'd13, 4'd3);
    tick();
    tick();
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd2;
    tick();
    bus.dividend = 4'd5;
    bus.divisor  = 4'd1;
    tick();
    bus.start = 1'b0;
    checkOutput("prot_busy", bus.busy, 1);
    tick();
    checkOutput("prot_done", bus.done, 1);
    checkOutput("prot_q", bus.quotient, 4);
    checkOutput("prot_r", bus.remainder, 1);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    checkOutput("prot_no_second_done", done_cnt, 0);
    checkOutput("prot_idle", bus.busy, 0);

    // Back-to-back with start held high: done every 6 cycles
    bus.start    = 1'b1;
    bus.dividend = 4'd12;
    bus.divisor  = 4'd5;
    tick();
    for (int n = 1; n <= 17; n++) begin
      tick();
      checkOutput($sformatf("b2b_done_n%0d", n), bus.done, (n % 6) == 5);
      checkOutput($sformatf("b2b_busy_n%0d", n), bus.busy, (n % 6) != 5);
      if ((n % 6) == 5) begin
        checkOutput("b2b_q", bus.quotient, 2);
        checkOutput("b2b_r", bus.remainder, 2);
      end
      if (n == 17) bus.start = 1'b0;
    end
    tick();

    // Reset mid-operation clears results, including a set zero flag
    doDiv("pre_rst", 4'd5, 4'd0);
    applyStimulus(4'd14, 4'd4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_q", bus.quotient, 0);
    checkOutput("midrst_r", bus.remainder, 0);
    checkOutput("midrst_done", bus.done, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_dbz", bus.div_by_zero, 0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    checkOutput("midrst_no_done", done_cnt, 0);
    doDiv("after_rst", 4'd14, 4'd4);

    // Exhaustive WIDTH=4 sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        doDiv("exh", 4'(a), 4'(b));
      end
    end

    // Random WIDTH=4 pairs
    for (int i = 0; i < 100; i++) begin
      doDiv("rnd4", 4'($urandom), 4'($urandom));
    end

    // Random WIDTH=8 pairs, with a zero divisor mixed in regularly
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = (i % 10 == 0) ? 8'd0 : 8'($urandom);
      doDiv8(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
